three_reg_file: RTL and testbench

// - Three-entry, single-write-port register file with all three entries visible at once on dedicated read ports.
// - Small configuration/state store: a host writes one entry per clock; downstream logic reads every entry continuously.
// - No read addressing, no handshake; a write is a single-cycle strobe.
//

---
 rtl/three_reg_file_pkg.sv | 20 ++
 rtl/three_reg_file_cell.sv | 22 ++
 rtl/three_reg_file.sv | 41 ++++
 tb/tb_three_reg_file.sv | 118 +++++++++++
 4 files changed

// File: rtl/three_reg_file_pkg.sv
// Shared sizing and entry addresses for the three-entry register file.
package three_reg_file_pkg;

    localparam int REG_ADDR_W = 2;
    localparam int NUM_REGS   = 3;

    localparam logic [REG_ADDR_W-1:0] REG0 = 2'd0;
    localparam logic [REG_ADDR_W-1:0] REG1 = 2'd1;
    localparam logic [REG_ADDR_W-1:0] REG2 = 2'd2;

    // Maps an entry index to its write address; unused codes fall to REG0.
    function automatic logic [REG_ADDR_W-1:0] reg_addr(input int idx);
        case (idx)
            1:       reg_addr = REG1;
            2:       reg_addr = REG2;
            default: reg_addr = REG0;
        endcase
    endfunction

endpackage

// File: rtl/three_reg_file_cell.sv
// One storage entry: a DATA_WIDTH register with async reset and load enable.
module reg_file_cell
    import three_reg_file_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RESET_VALUE;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/three_reg_file.sv
// Three-entry register file: one write port, every entry visible on its own read port.
module three_reg_file
    import three_reg_file_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [REG_ADDR_W-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    logic [NUM_REGS-1:0]                 load;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    // Address 3 matches no entry, so it silently drops the write.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        assign load[i] = write_enable && (write_address == reg_addr(i));

        reg_file_cell #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (load[i]),
            .d     (write_data),
            .q     (regs[i])
        );
    end

    assign read_data_0 = regs[0];
    assign read_data_1 = regs[1];
    assign read_data_2 = regs[2];

endmodule

// File: tb/tb_three_reg_file.sv
// Directed plus randomized bench for three_reg_file against an array model.
module tb_three_reg_file;

    logic       clk;
    logic       reset;
    logic       write_enable;
    logic [1:0] write_address;
    logic [7:0] write_data;
    logic [7:0] read_data_0;
    logic [7:0] read_data_1;
    logic [7:0] read_data_2;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [3];

    three_reg_file #(.DATA_WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_data_0   (read_data_0),
        .read_data_1   (read_data_1),
        .read_data_2   (read_data_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd0"}, read_data_0, model[0]);
        check({tag, ".rd1"}, read_data_1, model[1]);
        check({tag, ".rd2"}, read_data_2, model[2]);
    endtask

    // One clock of stimulus. Reset is applied mid-low-phase so its effect is
    // checked before the next rising edge; the model then applies any write.
    task automatic step(input string tag, input logic we, input logic [1:0] addr,
                        input logic [7:0] data, input logic rst);
        @(negedge clk);
        write_enable  = we;
        write_address = addr;
        write_data    = data;
        reset         = rst;
        #2;
        if (rst) begin
            for (int i = 0; i < 3; i++) model[i] = 8'h00;
            check_all({tag, ".async"});
        end
        @(posedge clk);
        #1;
        if (!rst && we && addr < 2'd3) model[addr] = data;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) model[i] = 8'h00;
        reset         = 1'b1;
        write_enable  = 1'b0;
        write_address = 2'd0;
        write_data    = 8'h00;

        // Reset with no prior writes, checked before any clock edge.
        #1;
        check_all("reset_initial");

        step("release", 1'b0, 2'd0, 8'h00, 1'b0);

        step("wr0", 1'b1, 2'd0, 8'h01, 1'b0);
        step("wr1", 1'b1, 2'd1, 8'h0F, 1'b0);
        step("wr2", 1'b1, 2'd2, 8'hFF, 1'b0);
        check("wr_final.rd0", read_data_0, 8'h01);
        check("wr_final.rd1", read_data_1, 8'h0F);
        check("wr_final.rd2", read_data_2, 8'hFF);

        for (int k = 0; k < 3; k++) step("we_low", 1'b0, 2'd1, 8'hAA, 1'b0);

        step("addr3", 1'b1, 2'd3, 8'h55, 1'b0);
        check("addr3.rd1_held", read_data_1, 8'h0F);

        step("last_wins_a", 1'b1, 2'd1, 8'h11, 1'b0);
        step("last_wins_b", 1'b1, 2'd1, 8'h22, 1'b0);
        check("last_wins.rd1", read_data_1, 8'h22);

        step("mid_reset", 1'b0, 2'd0, 8'h00, 1'b1);
        check("mid_reset.rd2", read_data_2, 8'h00);
        step("post_reset_wr2", 1'b1, 2'd2, 8'h3C, 1'b0);
        check("post_reset.rd2", read_data_2, 8'h3C);
        check("post_reset.rd0", read_data_0, 8'h00);

        step("wr_under_reset", 1'b1, 2'd0, 8'h77, 1'b1);
        check("wr_under_reset.rd0", read_data_0, 8'h00);

        for (int k = 0; k < 300; k++) begin
            step("rand",
                 1'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 8'($urandom),
                 1'($urandom_range(0, 24) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
